seq_match_scheduler: RTL and testbench

Time-multiplexed serial pattern-match controller: shares one pattern-compare engine among N_CH serial bit channels. A round-robin grant selects one channel per cycle and the engine updates that channel's stored bit history. Matches are reported with a channel tag, and a per-channel saturating match counter is kept. It sits in front of the FSM detector library as the scheduler and configurer for multi-channel sequence detection, default pattern 1101 with overlap.

---
 rtl/seq_match_pkg.sv | 35 +++
 rtl/seq_match_scheduler_rr_arbiter.sv | 39 +++
 rtl/seq_match_scheduler.sv | 123 ++++++++++++
 tb/tb_seq_match_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_match_pkg.sv
// Shared widths and helpers for the multi-channel serial pattern matcher.
package seq_match_pkg;

  // Upper bounds of the supported configuration space; the helpers below
  // operate at these widths, and callers zero-extend their narrower values.
  localparam int PAT_W_MAX = 16;
  localparam int LEN_W_MAX = 5;

  // Width of a channel index (at least one bit even for a single channel).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a pattern-length field able to hold 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Lengths beyond the physical history width behave as a full-width match.
  function automatic logic [LEN_W_MAX-1:0] clamp_len(input logic [LEN_W_MAX-1:0] len,
                                                     input int pat_w);
    if (int'(len) > pat_w) return LEN_W_MAX'(pat_w);
    return len;
  endfunction

  // True when the low 'len' bits of value and pattern agree; len = 0 never matches.
  function automatic logic masked_match(input logic [PAT_W_MAX-1:0] value,
                                        input logic [PAT_W_MAX-1:0] pattern,
                                        input logic [LEN_W_MAX-1:0] len);
    logic [PAT_W_MAX:0] mask;
    mask = ((PAT_W_MAX + 1)'(1) << len) - (PAT_W_MAX + 1)'(1);
    return (len != '0) && (((value ^ pattern) & mask[PAT_W_MAX-1:0]) == '0);
  endfunction

endpackage

// File: rtl/seq_match_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping.
module rr_arbiter
  import seq_match_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_any
);

  int              idx;
  logic [CH_W-1:0] idx_c;

  // Scan from ptr+1 around the ring and take the first valid channel.
  always_comb begin
    // NOTE: every output gets a default before the search loop, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_c     = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_c = CH_W'(idx);
      if (!grant_any && valid[idx_c]) begin
        grant_any    = 1'b1;
        grant_idx    = idx_c;
        grant[idx_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_match_scheduler.sv
// Time-multiplexed pattern matcher: one compare engine shared round-robin
// across N_CH serial channels, with per-channel history and match counters.
module seq_match_scheduler
  import seq_match_pkg::*;
#(
  parameter int               N_CH    = 4,
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1101),
  parameter int               RST_LEN = 4,
  localparam int              CH_W    = idx_w(N_CH),
  localparam int              LEN_W   = len_w(PAT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [N_CH-1:0]   ch_bit,
  output logic [N_CH-1:0]   ch_ready,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_count
);

  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(clamp_len(LEN_W_MAX'(RST_LEN), PAT_W));
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [CH_W-1:0]  PTR_RST  = CH_W'(N_CH - 1);

  // Active configuration and arbitration pointer.
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic [CH_W-1:0]  ptr_q;

  // Per-channel state.
  logic [PAT_W-1:0] hist_q [N_CH];
  logic [LEN_W-1:0] fill_q [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];

  // Grant path: configuration cycles block all consumption.
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;

  assign req      = cfg_we ? '0 : ch_valid;
  assign ch_ready = gnt;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .valid     (req),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // Shared engine working on the granted channel.
  logic [PAT_W-1:0] next_hist;
  logic [LEN_W:0]   fill_plus;
  logic [LEN_W-1:0] fill_next;
  logic             hit;

  // Shift the granted bit into that channel's history and evaluate the match.
  always_comb begin
    next_hist = {hist_q[gnt_idx][PAT_W-2:0], ch_bit[gnt_idx]};
    fill_plus = {1'b0, fill_q[gnt_idx]} + (LEN_W + 1)'(1);
    fill_next = (fill_q[gnt_idx] == FILL_MAX) ? FILL_MAX : fill_plus[LEN_W-1:0];
    hit       = gnt_any
             && (fill_plus >= {1'b0, len_q})
             && masked_match(PAT_W_MAX'(next_hist), PAT_W_MAX'(pattern_q),
                             LEN_W_MAX'(len_q));
  end

  // Configuration, arbitration pointer and per-channel history/counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      pattern_q <= RST_PAT;
      len_q     <= LEN_RST;
      ptr_q     <= PTR_RST;
      // NOTE: these arrays are a handful of flops, not a RAM, so clearing
      // them on reset (and on reconfiguration) is cheap and intended.
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else if (cfg_we) begin
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(LEN_W_MAX'(cfg_len), PAT_W));
      ptr_q     <= PTR_RST;
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else if (gnt_any) begin
      hist_q[gnt_idx] <= next_hist;
      fill_q[gnt_idx] <= fill_next;
      ptr_q           <= gnt_idx;
      if (hit && (cnt_q[gnt_idx] != '1)) begin
        cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
      end
    end
  end

  // Registered match report, one cycle after the consuming edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= hit;
      if (hit) match_ch <= gnt_idx;
    end
  end

  assign rd_count = cnt_q[rd_ch];

endmodule

// File: tb/tb_seq_match_scheduler.sv
// Self-checking bench for seq_match_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_seq_match_scheduler;

  localparam int N   = 4;
  localparam int PW  = 4;
  localparam int CW  = 2;
  localparam int CHW = 2;
  localparam int LW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   ch_valid = '0;
  logic [N-1:0]   ch_bit = '0;
  logic [N-1:0]   ch_ready;
  logic           cfg_we = 1'b0;
  logic [PW-1:0]  cfg_pattern = '0;
  logic [LW-1:0]  cfg_len = '0;
  logic           match_valid;
  logic [CHW-1:0] match_ch;
  logic [CHW-1:0] rd_ch = '0;
  logic [CW-1:0]  rd_count;

  int n_tests = 0;
  int n_fail  = 0;

  seq_match_scheduler #(
    .N_CH(N), .PAT_W(PW), .CNT_W(CW), .RST_PAT(4'b1101), .RST_LEN(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .rd_ch       (rd_ch),
    .rd_count    (rd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [PW-1:0] m_pat;
  int          m_len;
  bit          hq [N][$];
  int          m_cnt [N];
  int          m_ptr;
  bit          exp_mv;
  int          exp_mch;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      hq[i].delete();
      m_cnt[i] = 0;
    end
    m_ptr = N - 1;
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input logic cfg);
    if (cfg) return -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    int g;
    bit hit;
    if (!rst_n) begin
      m_pat = 4'b1101;
      m_len = 4;
      model_clear();
      exp_mv = 0;
      check("rst_match_valid", match_valid, 0);
      check("rst_rd_count", rd_count, 0);
    end else begin
      check("match_valid", match_valid, exp_mv);
      if (exp_mv) check("match_ch", match_ch, exp_mch);
      check("rd_count", rd_count, m_cnt[rd_ch]);
    end
    g = model_grant(ch_valid, cfg_we);
    check("ch_ready", ch_ready, (g < 0) ? 0 : (1 << g));
    exp_mv = 0;
    if (rst_n) begin
      if (cfg_we) begin
        m_pat = cfg_pattern;
        m_len = (int'(cfg_len) > PW) ? PW : int'(cfg_len);
        model_clear();
      end else if (g >= 0) begin
        hq[g].push_back(ch_bit[g]);
        if (hq[g].size() > PW) void'(hq[g].pop_front());
        hit = (m_len > 0) && (hq[g].size() >= m_len);
        for (int k = 0; k < m_len; k++) begin
          if (hit && hq[g][hq[g].size() - 1 - k] != m_pat[k]) hit = 0;
        end
        if (hit) begin
          exp_mv  = 1;
          exp_mch = g;
          if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
        end
        m_ptr = g;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ch_valid = '0;
    cfg_we   = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Sends n bits (MSB of seq first) on one channel; mask mirrors seq order,
  // with a 1 where match_valid rose right after that bit.
  task automatic feed(input int ch, input logic [15:0] seq, input int n,
                      output logic [15:0] mask);
    mask = '0;
    for (int i = 0; i < n; i++) begin
      ch_valid     = '0;
      ch_bit       = '0;
      ch_valid[ch] = 1'b1;
      ch_bit[ch]   = seq[n-1-i];
      tick();
      mask[n-1-i] = match_valid;
    end
    ch_valid = '0;
    ch_bit   = '0;
  endtask

  task automatic configure(input logic [PW-1:0] pat, input logic [LW-1:0] len);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    ch_valid    = '1;
    #1;
    check("cfg_ready_low", ch_ready, 0);
    tick();
    cfg_we   = 1'b0;
    ch_valid = '0;
  endtask

  task automatic read_cnt(input int ch, output logic [CW-1:0] v);
    rd_ch = CHW'(ch);
    #1;
    v = rd_count;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0]    m;
    logic [CW-1:0]  v;
    logic [N-1:0]   rr_exp [5];
    int             pulses;
    int             last_ch;
    logic [3:0]     rr_seq;

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset defaults.
    do_reset();
    check("reset_match_valid", match_valid, 0);
    check("reset_ready_idle", ch_ready, 0);
    for (int i = 0; i < N; i++) begin
      read_cnt(i, v);
      check("reset_count", v, 0);
    end

    // Default pattern 1101 with overlap.
    feed(0, 16'b1101101, 7, m);
    check("overlap_mask", m, 16'b0001001);
    read_cnt(0, v);
    check("overlap_count", v, 2);

    // Round-robin with all channels valid; only channel 2 sees 1101.
    do_reset();
    rr_seq  = 4'b1101;
    pulses  = 0;
    last_ch = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      ch_valid  = '1;
      ch_bit    = '0;
      ch_bit[2] = rr_seq[3 - cyc / 4];
      #1;
      if (cyc < 5) check("rr_grant", ch_ready, rr_exp[cyc]);
      tick();
      if (match_valid) begin
        pulses++;
        last_ch = int'(match_ch);
      end
    end
    ch_valid = '0;
    ch_bit   = '0;
    tick();
    check("rr_pulses", pulses, 1);
    check("rr_match_ch", last_ch, 2);
    for (int i = 0; i < N; i++) begin
      read_cnt(i, v);
      check("rr_count", v, (i == 2) ? 1 : 0);
    end

    // Near misses.
    do_reset();
    feed(0, 16'b11101, 5, m);
    check("near_miss_11101", m, 16'b00001);
    do_reset();
    feed(0, 16'b1011, 4, m);
    check("near_miss_1011", m, 0);

    // Reconfigure to 101 / length 3.
    configure(4'b0101, 3'd3);
    feed(1, 16'b10101, 5, m);
    check("cfg101_mask", m, 16'b00101);
    read_cnt(1, v);
    check("cfg101_count", v, 2);

    // Length 0 disables matching; counters cleared by configuration.
    configure(4'b1101, 3'd0);
    read_cnt(1, v);
    check("cfg_clears_count", v, 0);
    feed(1, 16'b1101, 4, m);
    check("len0_mask", m, 0);

    // Oversized length clamps to the full history width.
    configure(4'b1101, 3'd7);
    feed(2, 16'b1101, 4, m);
    check("len_clamp_mask", m, 16'b0001);

    // Counter saturation with five matches on channel 3.
    do_reset();
    feed(3, 16'b1101101101101101, 16, m);
    check("sat_mask", m, 16'b0001001001001001);
    read_cnt(3, v);
    check("sat_count", v, 3);

    // Async reset mid-pattern discards the partial history.
    do_reset();
    feed(0, 16'b110, 3, m);
    do_reset();
    feed(0, 16'b1, 1, m);
    check("after_reset_single", m, 0);
    feed(0, 16'b1101, 4, m);
    check("after_reset_fresh", m, 16'b0001);

    // Reset drops an active match pulse without a clock edge.
    check("pulse_before_reset", match_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_drop", match_valid, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic checked by the model every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        ch_valid    = N'($urandom);
        ch_bit      = N'($urandom);
        rd_ch       = CHW'($urandom);
        cfg_we      = ($urandom_range(0, 79) == 0);
        cfg_pattern = PW'($urandom);
        cfg_len     = LW'($urandom_range(0, 7));
        tick();
      end
    end
    ch_valid = '0;
    cfg_we   = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
